sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO; successor to the fixed 8x64 buffer.

---
 rtl/sync_fifo_param_pkg.sv | 20 ++
 rtl/sync_fifo_param_if.sv | 36 +++
 rtl/fifo_ram_2p.sv | 29 ++
 rtl/sync_fifo_param.sv | 128 ++++++++++++
 tb/tb_sync_fifo_param.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the parametrised FIFO: read-mode encodings and a
// constant-foldable ceiling log2 used to size pointers and the occupancy count.
package sync_fifo_param_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle for sync_fifo_param. The FIFO sits on the
// slave side; whoever drives writes/reads and observes status uses master.
interface sync_fifo_param_if
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) ();

    logic                    flush;
    logic                    wr_en;
    logic [DATA_W-1:0]       wr_data;
    logic                    rd_en;
    logic [DATA_W-1:0]       rd_data;
    logic                    rd_valid;
    logic                    full;
    logic                    empty;
    logic                    almost_full;
    logic                    almost_empty;
    logic [clog2(DEPTH):0]   count;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram_2p.sv
// Storage array for the FIFO: synchronous write port, asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the pointers.
module fifo_ram_2p
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store on the edge when the top level has accepted a write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, standard or first-word-fall-through read, synchronous flush and
// sticky overflow/underflow. All status flags decode from the registered count,
// so they update the cycle after the edge that accepted the operation.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = FIFO_MODE_STD
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_param_if.slave   bus
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              full_w;
    logic              empty_w;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] ram_rd_data;

    assign full_w  = (count_q == FULL_CNT);
    assign empty_w = (count_q == '0);

    // flush discards same-cycle requests, so it gates acceptance outright.
    assign wr_acc = bus.wr_en && !full_w  && !bus.flush;
    assign rd_acc = bus.rd_en && !empty_w && !bus.flush;

    fifo_ram_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (bus.wr_data),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    // Pointers wrap naturally at DEPTH; count tracks net accepted ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags; a request coinciding with flush is not flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_en && full_w)  overflow_q  <= 1'b1;
            if (bus.rd_en && empty_w) underflow_q <= 1'b1;
        end
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head entry is always presented; valid whenever anything is stored.
            assign bus.rd_data  = ram_rd_data;
            assign bus.rd_valid = !empty_w;
        end else begin : g_std
            logic [DATA_W-1:0] rd_data_q;
            logic              rd_valid_q;

            // Registered read: capture the head on an accepted read, pulse valid once.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else if (bus.flush) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= ram_rd_data;
                end
            end

            assign bus.rd_data  = rd_data_q;
            assign bus.rd_valid = rd_valid_q;
        end
    endgenerate

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= AF_CNT);
    assign bus.almost_empty = (count_q <= AE_CNT);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: one standard-read instance and one FWFT instance, DEPTH=8,
// DATA_W=8, AF_THRESH=6, AE_THRESH=2. Inputs change #1 after the rising edge
// and outputs are sampled there too.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(8), .DEPTH(8)) bus_s ();
    sync_fifo_param_if #(.DATA_W(8), .DEPTH(8)) bus_f ();

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)
    ) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)
    ) dut_f (
        .clk (clk),
        .rst (rst),
        .bus (bus_f)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_s(input logic [7:0] d);
        bus_s.wr_en   = 1'b1;
        bus_s.wr_data = d;
        tick();
        bus_s.wr_en   = 1'b0;
    endtask

    task automatic rd_s();
        bus_s.rd_en = 1'b1;
        tick();
        bus_s.rd_en = 1'b0;
    endtask

    task automatic flush_s();
        bus_s.flush = 1'b1;
        tick();
        bus_s.flush = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus_s.flush   = 1'b0;
        bus_s.wr_en   = 1'b0;
        bus_s.wr_data = 8'h00;
        bus_s.rd_en   = 1'b0;
        bus_f.flush   = 1'b0;
        bus_f.wr_en   = 1'b0;
        bus_f.wr_data = 8'h00;
        bus_f.rd_en   = 1'b0;
        tick();
        tick();

        check("rst_count",    32'(bus_s.count), 0);
        check("rst_empty",    32'(bus_s.empty), 1);
        check("rst_ae",       32'(bus_s.almost_empty), 1);
        check("rst_full",     32'(bus_s.full), 0);
        check("rst_af",       32'(bus_s.almost_full), 0);
        check("rst_rd_data",  32'(bus_s.rd_data), 0);
        check("rst_rd_valid", 32'(bus_s.rd_valid), 0);
        check("rst_ovf",      32'(bus_s.overflow), 0);
        check("rst_udf",      32'(bus_s.underflow), 0);
        rst = 1'b0;
        tick();

        // Fill 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            wr_s(8'(i));
            check("fill_count", 32'(bus_s.count), 32'(i));
            check("fill_af",    32'(bus_s.almost_full), 32'(i >= 6));
            check("fill_ae",    32'(bus_s.almost_empty), 32'(i <= 2));
            check("fill_full",  32'(bus_s.full), 32'(i == 8));
        end
        wr_s(8'h99);
        check("ovf_set",   32'(bus_s.overflow), 1);
        check("ovf_count", 32'(bus_s.count), 8);

        // Drain with registered read
        for (int i = 1; i <= 8; i++) begin
            rd_s();
            check("drain_valid", 32'(bus_s.rd_valid), 1);
            check("drain_data",  32'(bus_s.rd_data), 32'(i));
            tick();
            check("drain_valid_low", 32'(bus_s.rd_valid), 0);
            check("drain_hold",      32'(bus_s.rd_data), 32'(i));
        end
        check("drain_empty", 32'(bus_s.empty), 1);
        check("drain_udf",   32'(bus_s.underflow), 0);

        // Reset mid-burst
        bus_s.wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_s.wr_data = 8'(8'h31 + i);
            tick();
        end
        check("burst_count", 32'(bus_s.count), 3);
        #2;
        rst         = 1'b1;
        bus_s.wr_en = 1'b0;
        #1;
        check("mid_rst_count",    32'(bus_s.count), 0);
        check("mid_rst_empty",    32'(bus_s.empty), 1);
        check("mid_rst_rd_data",  32'(bus_s.rd_data), 0);
        check("mid_rst_rd_valid", 32'(bus_s.rd_valid), 0);
        check("mid_rst_ovf",      32'(bus_s.overflow), 0);
        check("mid_rst_ae",       32'(bus_s.almost_empty), 1);
        tick();
        rst = 1'b0;
        tick();
        rd_s();
        check("post_rst_udf",   32'(bus_s.underflow), 1);
        check("post_rst_valid", 32'(bus_s.rd_valid), 0);
        check("post_rst_count", 32'(bus_s.count), 0);
        flush_s();
        check("flush_udf_clr", 32'(bus_s.underflow), 0);

        // Wrap: interleaved single write/read, 20 times
        for (int i = 0; i < 20; i++) begin
            wr_s(8'(8'h10 + i));
            check("wrap_ae_w",  32'(bus_s.almost_empty), 1);
            check("wrap_cnt_w", 32'(bus_s.count), 1);
            rd_s();
            check("wrap_data",  32'(bus_s.rd_data), 32'(8'h10 + i));
            check("wrap_valid", 32'(bus_s.rd_valid), 1);
            check("wrap_ae_r",  32'(bus_s.almost_empty), 1);
        end

        // Simultaneous at full
        for (int i = 0; i < 8; i++) wr_s(8'(8'h20 + i));
        bus_s.wr_en   = 1'b1;
        bus_s.rd_en   = 1'b1;
        bus_s.wr_data = 8'h55;
        tick();
        bus_s.wr_en = 1'b0;
        bus_s.rd_en = 1'b0;
        check("simf_count", 32'(bus_s.count), 7);
        check("simf_ovf",   32'(bus_s.overflow), 1);
        check("simf_valid", 32'(bus_s.rd_valid), 1);
        check("simf_data",  32'(bus_s.rd_data), 32'h20);
        for (int i = 0; i < 7; i++) begin
            rd_s();
            check("simf_drain", 32'(bus_s.rd_data), 32'(8'h21 + i));
        end
        check("simf_empty", 32'(bus_s.empty), 1);
        flush_s();

        // Simultaneous at empty
        bus_s.wr_en   = 1'b1;
        bus_s.rd_en   = 1'b1;
        bus_s.wr_data = 8'h66;
        tick();
        bus_s.wr_en = 1'b0;
        bus_s.rd_en = 1'b0;
        check("sime_count", 32'(bus_s.count), 1);
        check("sime_udf",   32'(bus_s.underflow), 1);
        check("sime_valid", 32'(bus_s.rd_valid), 0);

        // Simultaneous at count=4
        wr_s(8'h67);
        wr_s(8'h68);
        wr_s(8'h69);
        check("simm_pre", 32'(bus_s.count), 4);
        bus_s.wr_en   = 1'b1;
        bus_s.rd_en   = 1'b1;
        bus_s.wr_data = 8'h6A;
        tick();
        bus_s.wr_en = 1'b0;
        bus_s.rd_en = 1'b0;
        check("simm_count", 32'(bus_s.count), 4);
        check("simm_data",  32'(bus_s.rd_data), 32'h66);
        flush_s();

        // Flush with concurrent write at count=5, overflow set
        for (int i = 0; i < 8; i++) wr_s(8'(8'h70 + i));
        wr_s(8'hEE);
        for (int i = 0; i < 3; i++) rd_s();
        check("fl_pre_count", 32'(bus_s.count), 5);
        check("fl_pre_ovf",   32'(bus_s.overflow), 1);
        bus_s.flush   = 1'b1;
        bus_s.wr_en   = 1'b1;
        bus_s.wr_data = 8'h77;
        tick();
        bus_s.flush = 1'b0;
        bus_s.wr_en = 1'b0;
        check("fl_count", 32'(bus_s.count), 0);
        check("fl_empty", 32'(bus_s.empty), 1);
        check("fl_ovf",   32'(bus_s.overflow), 0);
        check("fl_udf",   32'(bus_s.underflow), 0);
        check("fl_valid", 32'(bus_s.rd_valid), 0);
        check("fl_hold",  32'(bus_s.rd_data), 32'h72);
        tick();
        check("fl_discard", 32'(bus_s.count), 0);
        wr_s(8'h88);
        rd_s();
        check("fl_after", 32'(bus_s.rd_data), 32'h88);

        // FWFT instance
        check("fwft_idle_valid", 32'(bus_f.rd_valid), 0);
        check("fwft_idle_empty", 32'(bus_f.empty), 1);
        bus_f.wr_en   = 1'b1;
        bus_f.wr_data = 8'hA5;
        tick();
        bus_f.wr_en = 1'b0;
        check("fwft_valid", 32'(bus_f.rd_valid), 1);
        check("fwft_data",  32'(bus_f.rd_data), 32'hA5);
        bus_f.rd_en = 1'b1;
        tick();
        bus_f.rd_en = 1'b0;
        check("fwft_pop_valid", 32'(bus_f.rd_valid), 0);
        check("fwft_pop_empty", 32'(bus_f.empty), 1);
        bus_f.wr_en = 1'b1;
        bus_f.wr_data = 8'hB1;
        tick();
        bus_f.wr_data = 8'hB2;
        tick();
        bus_f.wr_en = 1'b0;
        check("fwft_head",  32'(bus_f.rd_data), 32'hB1);
        check("fwft_count", 32'(bus_f.count), 2);
        bus_f.rd_en = 1'b1;
        tick();
        bus_f.rd_en = 1'b0;
        check("fwft_next",       32'(bus_f.rd_data), 32'hB2);
        check("fwft_next_valid", 32'(bus_f.rd_valid), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
